store_outstanding_tracker: RTL and testbench
============================================

STORE_OUTSTANDING_TRACKER -- requirements
Module: store_outstanding_tracker

Interface
REQ-001 SHALL have parameter MaxOutstandingStores, default 7, maximum number of in-flight stores, legal range 1..15.
REQ-002 SHALL have parameter PLEN, default 34, physical address width.
REQ-003 SHALL have parameter CachedBase, default 34'h0_8000_0000, base of the single cached region.
REQ-004 SHALL have parameter CachedLen, default 34'h0_4000_0000, length of the cached region.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port st_req_i, input, 1, store issue request from the store unit.
REQ-008 SHALL have port st_addr_i, input, PLEN, physical address of the requesting store.
REQ-009 SHALL have port st_gnt_o, output, 1, store accepted this cycle (combinational).
REQ-010 SHALL have port st_ack_i, input, 1, memory write acknowledge; one per accepted store.
REQ-011 SHALL have port fence_i, input, 1, one-cycle fence/drain request.
REQ-012 SHALL have port fence_done_o, output, 1, one-cycle pulse when the drain completes.
REQ-013 SHALL have port outstanding_o, output, 4, current in-flight store count.
REQ-014 SHALL have ports full_o and empty_o, output, 1 each: count==MaxOutstandingStores and count==0.
REQ-015 SHALL have port underflow_o, output, 1, sticky error flag set on an ack with count 0.

Function
REQ-016 Cached-address test SHALL be CachedBase <= st_addr_i < CachedBase+CachedLen, computed in PLEN+1 bits with no wrap.
REQ-017 FSM states SHALL be IDLE, DRAIN, DONE; the reset state is IDLE.
REQ-018 In IDLE, st_gnt_o SHALL be 1 iff st_req_i and count<MaxOutstandingStores and (address cached, or count==0 with no ack this cycle).
REQ-019 In DRAIN and DONE, st_gnt_o SHALL be 0 regardless of inputs.
REQ-020 Count update per cycle SHALL be count + st_gnt_o - (st_ack_i and count>0); a grant and an ack in the same cycle leave the count unchanged.
REQ-021 In IDLE with full_o=1, a same-cycle ack SHALL NOT enable a grant; the grant follows one cycle later.
REQ-022 An ack with count==0 SHALL leave the count at 0 and set underflow_o from the next cycle until reset.
REQ-023 IDLE + fence_i SHALL go to DRAIN, even when count==0; a store requested in the same cycle SHALL NOT be granted.
REQ-024 DRAIN SHALL go to DONE in the cycle after the count reaches 0, including reaching 0 through an ack in that cycle.
REQ-025 DONE SHALL assert fence_done_o for exactly one cycle, then return to IDLE.
REQ-026 fence_i outside IDLE SHALL be ignored.
REQ-027 fence latency with count 0 SHALL be: fence_i at cycle N, DRAIN at N+1, DONE (fence_done_o=1) at N+2, IDLE at N+3.
REQ-028 outstanding_o, full_o and empty_o SHALL be registered-state derived, with no combinational path from inputs.

Reset
REQ-029 On rst_ni low, asynchronously: count=0, state=IDLE, underflow_o=0, fence_done_o=0, st_gnt_o=0.
REQ-030 A reset asserted during DRAIN SHALL abandon the fence with no fence_done_o pulse; outstanding stores are forgotten.
REQ-031 After rst_ni deasserts, a request in the first clock cycle SHALL be grantable.

Verification
REQ-032 7 back-to-back cached stores at 0x8000_0000 with no acks -> gnt for 7 cycles, outstanding_o=7 and full_o=1, 8th request gnt=0; 1 ack -> 8th request granted one cycle later.
REQ-033 Non-cached store at 0x1_0000 with count=2 -> gnt=0 until two acks return count to 0, then gnt=1 the next cycle.
REQ-034 Count=3, simultaneous gnt and ack -> outstanding_o stays 3.
REQ-035 Count=2, fence_i -> no grants while draining; after the second ack, fence_done_o pulses exactly once, then cached stores are granted again.
REQ-036 Ack at count 0 -> outstanding_o=0 and underflow_o=1, held until rst_ni low.
REQ-037 Reset asserted in DRAIN with count=4 -> outstanding_o=0, IDLE, no fence_done_o pulse; fence with count 0 -> fence_done_o at N+2.

Source files
------------

// File: rtl/store_outstanding_tracker.sv
// Tracks in-flight stores. Stores to non-cached addresses are only allowed when nothing is outstanding.
// A fence blocks new grants until every outstanding store has been acknowledged, then pulses fence_done_o once.
module store_outstanding_tracker #(
  parameter int unsigned     MaxOutstandingStores = 7,
  parameter int unsigned     PLEN                 = 34,
  parameter logic [PLEN-1:0] CachedBase           = 34'h0_8000_0000,
  parameter logic [PLEN-1:0] CachedLen            = 34'h0_4000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            st_req_i,
  input  logic [PLEN-1:0] st_addr_i,
  output logic            st_gnt_o,
  input  logic            st_ack_i,
  input  logic            fence_i,
  output logic            fence_done_o,
  output logic [3:0]      outstanding_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            underflow_o
);

  localparam int unsigned     CntW     = 4;
  localparam logic [CntW-1:0] MaxCnt   = CntW'(MaxOutstandingStores);
  // Region bounds are one bit wider so the end of the region cannot wrap.
  localparam logic [PLEN:0]   RegionLo = {1'b0, CachedBase};
  localparam logic [PLEN:0]   RegionHi = {1'b0, CachedBase} + {1'b0, CachedLen};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q, count_d;
  logic            underflow_q;
  logic            fence_done_q;
  logic            addr_cached;
  logic            ack_valid;
  logic            gnt;

  always_comb begin
    addr_cached = ({1'b0, st_addr_i} >= RegionLo) && ({1'b0, st_addr_i} < RegionHi);
  end

  // A non-cached store needs a fully idle memory path, including no ack landing this cycle.
  always_comb begin
    gnt = 1'b0;
    if (rst_ni && (state_q == IDLE) && !fence_i && st_req_i && (count_q < MaxCnt)) begin
      gnt = addr_cached || ((count_q == '0) && !st_ack_i);
    end
  end

  always_comb begin
    ack_valid = st_ack_i && (count_q != '0);
    count_d   = count_q + CntW'(gnt) - CntW'(ack_valid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      count_q      <= '0;
      underflow_q  <= 1'b0;
      fence_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      underflow_q  <= underflow_q || (st_ack_i && (count_q == '0));
      fence_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fence_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (count_d == '0) begin
            state_q      <= DONE;
            fence_done_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st_gnt_o      = gnt;
  assign fence_done_o  = fence_done_q;
  assign outstanding_o = count_q;
  assign full_o        = (count_q == MaxCnt);
  assign empty_o       = (count_q == '0);
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_store_outstanding_tracker.sv
// Scoreboard bench for store_outstanding_tracker: the driver predicts each cycle's outputs from a
// behavioural model and queues them; a monitor samples the DUT mid-cycle and compares.
module tb_store_outstanding_tracker;

  localparam int MaxSt = 7;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        st_req_i = 1'b0;
  logic [33:0] st_addr_i = '0;
  logic        st_gnt_o;
  logic        st_ack_i = 1'b0;
  logic        fence_i = 1'b0;
  logic        fence_done_o;
  logic [3:0]  outstanding_o;
  logic        full_o;
  logic        empty_o;
  logic        underflow_o;

  store_outstanding_tracker dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .st_req_i     (st_req_i),
    .st_addr_i    (st_addr_i),
    .st_gnt_o     (st_gnt_o),
    .st_ack_i     (st_ack_i),
    .fence_i      (fence_i),
    .fence_done_o (fence_done_o),
    .outstanding_o(outstanding_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       gnt;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       uf;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: count of stores in flight, sticky underflow, fence progress.
  int m_cnt = 0;
  bit m_uf = 1'b0;
  bit m_drain = 1'b0;
  bit m_done = 1'b0;

  localparam logic [33:0] Base = 34'h0_8000_0000;
  localparam logic [33:0] CEnd = 34'h0_C000_0000;
  localparam logic [33:0] NonC = 34'h0_0001_0000;

  function automatic bit is_cached(input logic [33:0] a);
    longint v;
    v = longint'(a);
    return (v >= 64'h8000_0000) && (v < 64'h8000_0000 + 64'h4000_0000);
  endfunction

  task automatic cyc(input bit rst, input bit req, input logic [33:0] addr, input bit ack, input bit fence);
    exp_t e;
    bit   idle, g, dec, nd, ndr;
    @(negedge clk);
    rst_ni    = rst;
    st_req_i  = req;
    st_addr_i = addr;
    st_ack_i  = ack;
    fence_i   = fence;
    if (!rst) begin
      m_cnt = 0; m_uf = 1'b0; m_drain = 1'b0; m_done = 1'b0;
    end
    idle = !m_drain && !m_done;
    g = rst && idle && req && !fence && (m_cnt < MaxSt) && (is_cached(addr) || (m_cnt == 0 && !ack));
    e.gnt   = g;
    e.cnt   = 4'(m_cnt);
    e.full  = (m_cnt == MaxSt);
    e.empty = (m_cnt == 0);
    e.uf    = m_uf;
    e.fd    = m_done;
    sb.push_back(e);
    if (rst) begin
      dec = ack && (m_cnt > 0);
      if (ack && m_cnt == 0) m_uf = 1'b1;
      m_cnt = m_cnt + int'(g) - int'(dec);
      nd  = m_drain && (m_cnt == 0);
      ndr = (idle && fence) || (m_drain && m_cnt != 0);
      m_done  = nd;
      m_drain = ndr;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are sampled well after the negedge drive and away from the posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("st_gnt_o",      int'(st_gnt_o),      int'(e.gnt));
        chk("outstanding_o", int'(outstanding_o), int'(e.cnt));
        chk("full_o",        int'(full_o),        int'(e.full));
        chk("empty_o",       int'(empty_o),       int'(e.empty));
        chk("underflow_o",   int'(underflow_o),   int'(e.uf));
        chk("fence_done_o",  int'(fence_done_o),  int'(e.fd));
      end
    end
  end

  initial begin
    logic [33:0] a;
    bit r, rq, ak, fc;
    // Reset, then a request in the very first cycle after release.
    cyc(0, 1, Base, 0, 0);
    cyc(0, 0, Base, 0, 0);
    cyc(1, 1, NonC, 0, 0);
    cyc(1, 0, Base, 1, 0);
    // Fill to seven, blocked eighth, ack while full, grant one cycle later.
    for (int i = 0; i < 7; i++) cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 1, 0);
    cyc(1, 1, Base, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, Base, 1, 0);
    // Non-cached store waits until the count is zero with no same-cycle ack.
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, NonC, 0, 0);
    cyc(1, 1, NonC, 1, 0);
    cyc(1, 1, NonC, 1, 0);
    cyc(1, 1, NonC, 0, 0);
    cyc(1, 0, Base, 1, 0);
    // Simultaneous grant and ack at count three.
    for (int i = 0; i < 3; i++) cyc(1, 1, CEnd - 34'd1, 0, 0);
    cyc(1, 1, Base, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, Base, 1, 0);
    // Fence with two outstanding; requests ignored while draining.
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 0, 1);
    cyc(1, 1, Base, 0, 1);
    cyc(1, 1, Base, 1, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 1, 1);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 0, Base, 1, 0);
    // Region boundaries.
    cyc(1, 1, CEnd, 0, 0);
    cyc(1, 1, Base - 34'd1, 0, 0);
    cyc(1, 1, Base, 0, 0);
    cyc(1, 1, CEnd, 0, 0);
    cyc(1, 1, Base - 34'd1, 0, 0);
    cyc(1, 1, 34'h3_FFFF_FFFF, 0, 0);
    cyc(1, 0, Base, 1, 0);
    // Ack at count zero sets sticky underflow.
    cyc(1, 0, Base, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, Base, 0, 0);
    // Reset in the middle of a drain, then fence at count zero.
    for (int i = 0; i < 4; i++) cyc(1, 1, Base, 0, 0);
    cyc(1, 0, Base, 0, 1);
    cyc(1, 0, Base, 0, 0);
    cyc(0, 0, Base, 0, 0);
    cyc(1, 0, Base, 0, 0);
    cyc(1, 0, Base, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, Base, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0:       a = Base;
        1:       a = CEnd - 34'd1;
        2:       a = CEnd;
        3:       a = Base - 34'd1;
        4:       a = 34'h3_FFFF_FFFF;
        5:       a = Base + 34'($urandom_range(0, 32'h3FFF_FFFF));
        default: a = {2'($urandom), 32'($urandom)};
      endcase
      r  = ($urandom_range(0, 199) != 0);
      rq = ($urandom_range(0, 2) != 0);
      ak = (m_cnt > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      fc = ($urandom_range(0, 24) == 0);
      cyc(r, rq, a, ak, fc);
    end
    cyc(1, 0, Base, 0, 0);
    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
